exp_unit_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `exponent` unit (IEEE-754 single-precision e^x, `X`/`enb` in, `Y`/`ack` out) among `NUM_REQ` requesters in the CNN datapath (softmax and activation stages). It accepts one operand per grant and drives the unit's restart protocol: `enb` low with `X` set, then `enb` high until `ack`. It returns the result tagged with the requester ID on a shared response channel. A watchdog reports an operation that never acknowledges.

---
 rtl/exp_unit_arbiter_if.sv | 32 +++
 rtl/exp_unit_arbiter.sv | 169 ++++++++++++++++
 tb/tb_exp_unit_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exp_unit_arbiter_if.sv
// Bundle of the requester, response and exponent-unit channels seen by exp_unit_arbiter.
// master is the arbiter side; slave is the surrounding datapath / exponent unit.
interface exp_unit_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_x;
    logic [NUM_REQ-1:0]            req_ready;

    logic                          resp_valid;
    logic                          resp_ready;
    logic [ID_W-1:0]               resp_id;
    logic [DATA_WIDTH-1:0]         resp_y;
    logic                          resp_timeout;

    logic [DATA_WIDTH-1:0]         exp_x;
    logic                          exp_enb;
    logic [DATA_WIDTH-1:0]         exp_y;
    logic                          exp_ack;

    modport master (
        input  req_valid, req_x, resp_ready, exp_y, exp_ack,
        output req_ready, resp_valid, resp_id, resp_y, resp_timeout, exp_x, exp_enb
    );

    modport slave (
        output req_valid, req_x, resp_ready, exp_y, exp_ack,
        input  req_ready, resp_valid, resp_id, resp_y, resp_timeout, exp_x, exp_enb
    );
endinterface

// File: rtl/exp_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one e^x unit among NUM_REQ requesters:
// grant, restart the unit (enb low then high), collect the result or time out, respond with the ID.
module exp_unit_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic               clk,
    input  logic               rst,
    exp_unit_arbiter_if.master arb_if,
    output logic               busy
);
    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [ID_W-1:0]  PTR_RST   = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic                  enb_q, enb_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] y_q, y_d;
    logic                  to_q, to_d;
    logic                  rv_q, rv_d;
    logic                  busy_q, busy_d;

    logic [ID_W:0]         cand_s;
    logic                  hit_s;
    logic                  found_s;
    logic [ID_W-1:0]       pick_s;
    logic [DATA_WIDTH-1:0] sel_x_s;
    logic [NUM_REQ-1:0]    grant_s;

    // Round-robin search starting one past the last served requester, wrapping at NUM_REQ.
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_s  = {1'b0, ptr_q} + (ID_W + 1)'(off);
            cand_s  = (cand_s >= NUM_REQ_W) ? (cand_s - NUM_REQ_W) : cand_s;
            hit_s   = !found_s && arb_if.req_valid[cand_s[ID_W-1:0]];
            pick_s  = hit_s ? cand_s[ID_W-1:0] : pick_s;
            found_s = found_s | hit_s;
        end
    end

    // Operand of the selected requester.
    always_comb begin
        sel_x_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_x_s = (pick_s == ID_W'(i)) ? arb_if.req_x[i*DATA_WIDTH +: DATA_WIDTH] : sel_x_s;
        end
    end

    // Next-state and datapath update for the IDLE/LOAD/RUN/RESP sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        x_d     = x_q;
        enb_d   = enb_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        to_d    = to_q;
        rv_d    = rv_q;
        grant_s = '0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    grant_s[pick_s] = 1'b1;
                    x_d             = sel_x_s;
                    id_d            = pick_s;
                    state_d         = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // enb is still low this cycle, which restarts the unit; a stale ack is ignored.
                cnt_d   = '0;
                enb_d   = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_ONE;
                if (arb_if.exp_ack) begin
                    y_d     = arb_if.exp_y;
                    to_d    = 1'b0;
                    rv_d    = 1'b1;
                    enb_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    y_d     = '0;
                    to_d    = 1'b1;
                    rv_d    = 1'b1;
                    enb_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RESP: begin
                if (arb_if.resp_ready) begin
                    ptr_d   = id_q;
                    rv_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                enb_d   = 1'b0;
                rv_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= PTR_RST;
            id_q    <= '0;
            x_q     <= '0;
            enb_q   <= 1'b0;
            cnt_q   <= '0;
            y_q     <= '0;
            to_q    <= 1'b0;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            x_q     <= x_d;
            enb_q   <= enb_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            to_q    <= to_d;
            rv_q    <= rv_d;
            busy_q  <= busy_d;
        end
    end

    assign arb_if.req_ready    = grant_s;
    assign arb_if.resp_valid   = rv_q;
    assign arb_if.resp_id      = id_q;
    assign arb_if.resp_y       = y_q;
    assign arb_if.resp_timeout = to_q;
    assign arb_if.exp_x        = x_q;
    assign arb_if.exp_enb      = enb_q;
    assign busy                = busy_q;

endmodule

// File: tb/tb_exp_unit_arbiter.sv
// Directed bench for exp_unit_arbiter with a behavioural exponent unit (ack 7 cycles after enb rises).
module tb_exp_unit_arbiter;
    localparam int K_LAT = 7;

    logic clk;
    logic rst;
    logic busy;
    logic stub_ok;
    int   ack_cnt;
    int   n_assert;
    int   n_fail;
    int   cyc;
    int   n;
    int   last_g;

    exp_unit_arbiter_if #(.DATA_WIDTH(32), .NUM_REQ(4), .ID_W(2)) bus ();

    exp_unit_arbiter #(
        .DATA_WIDTH(32),
        .NUM_REQ   (4),
        .ID_W      (2),
        .TIMEOUT   (15)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .arb_if(bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table of hand-computed e^x results; other operands map to a distinct pattern.
    function automatic logic [31:0] exp_model(input logic [31:0] x);
        case (x)
            32'h3F566CF4: exp_model = 32'h4013E47A;   // e^0.8376 = 2.31082
            32'hBF75C28F: exp_model = 32'h3EC40A27;   // e^-0.96  = 0.38289
            default:      exp_model = x ^ 32'h0F0F_0F0F;
        endcase
    endfunction

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        m   = 1.0 + real'(b[22:0]) / 8388608.0;
        e   = int'(b[30:23]) - 127;
        f2r = (b[31] ? -m : m) * (2.0 ** e);
    endfunction

    always @(posedge clk) begin
        if (!bus.exp_enb) ack_cnt <= 0;
        else              ack_cnt <= ack_cnt + 1;
    end
    assign bus.exp_ack = stub_ok && bus.exp_enb && (ack_cnt == K_LAT - 1);
    assign bus.exp_y   = exp_model(bus.exp_x);

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input real obs, input real exp, input real tol);
        n_assert++;
        assert (((obs - exp) < tol) && ((exp - obs) < tol)) else begin
            n_fail++;
            $error("FAIL %s: observed %f expected %f", tag, obs, exp);
        end
    endtask

    task automatic set_x(input int idx, input logic [31:0] v);
        bus.req_x[idx*32 +: 32] = v;
    endtask

    task automatic wait_resp(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (bus.resp_valid !== 1'b1 && cnt < 60);
    endtask

    // Single granted operation; leaves the bench in the first RESP cycle.
    task automatic do_op(input int req, input logic [31:0] x, input int lat, input logic to,
                         input logic [31:0] y, input string tag);
        int c;
        set_x(req, x);
        bus.req_valid = 4'b0001 << req;
        #1;
        chk({tag, "_grant"}, bus.req_ready, 64'(4'b0001 << req));
        tick();
        bus.req_valid = 4'b0000;
        wait_resp(c);
        chk({tag, "_latency"}, c, lat);
        chk({tag, "_id"}, bus.resp_id, req);
        chk({tag, "_timeout"}, bus.resp_timeout, to);
        chk({tag, "_y"}, bus.resp_y, y);
    endtask

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        cyc            = 0;
        stub_ok        = 1'b1;
        rst            = 1'b1;
        bus.req_valid  = 4'b0000;
        bus.req_x      = '0;
        bus.resp_ready = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", bus.req_ready, 4'b0000);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_resp_id", bus.resp_id, 2'd0);
        chk("rst_resp_y", bus.resp_y, 32'h0);
        chk("rst_resp_timeout", bus.resp_timeout, 1'b0);
        chk("rst_exp_x", bus.exp_x, 32'h0);
        chk("rst_exp_enb", bus.exp_enb, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst            = 1'b0;
        bus.resp_ready = 1'b1;

        // Single request from requester 1.
        set_x(1, 32'h3F566CF4);
        bus.req_valid = 4'b0010;
        #1;
        chk("t1_grant", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = 4'b0000;
        chk("t1_ready_drop", bus.req_ready, 4'b0000);
        chk("t1_load_enb", bus.exp_enb, 1'b0);
        chk("t1_load_x", bus.exp_x, 32'h3F566CF4);
        chk("t1_busy", busy, 1'b1);
        tick();
        chk("t1_run_enb", bus.exp_enb, 1'b1);
        wait_resp(n);
        chk("t1_latency", n + 1, 8);
        chk("t1_id", bus.resp_id, 2'd1);
        chk("t1_timeout", bus.resp_timeout, 1'b0);
        chk("t1_y", bus.resp_y, 32'h4013E47A);
        chk_near("t1_y_val", f2r(bus.resp_y), 2.3108, 1.0e-4);
        chk("t1_resp_enb", bus.exp_enb, 1'b0);
        tick();
        chk("t1_post_valid", bus.resp_valid, 1'b0);
        chk("t1_post_busy", busy, 1'b0);

        // Negative operand from requester 3.
        do_op(3, 32'hBF75C28F, 8, 1'b0, 32'h3EC40A27, "t2");
        chk_near("t2_y_val", f2r(bus.resp_y), 0.3829, 2.0e-4);
        tick();

        // Contention: all four valid from reset.
        rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) set_x(i, 32'h3F80_0000 + i);
        bus.req_valid = 4'b1111;
        rst           = 1'b0;
        #1;
        last_g = 0;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (bus.req_ready == 4'b0000 && n < 30) begin
                tick();
                n++;
            end
            chk("t3_grant", bus.req_ready, 64'(4'b0001 << (g % 4)));
            if (g > 0) chk("t3_gap", cyc - last_g, 10);
            last_g = cyc;
            tick();
            wait_resp(n);
            chk("t3_latency", n, 8);
            chk("t3_id", bus.resp_id, g % 4);
            chk("t3_y", bus.resp_y, exp_model(32'h3F80_0000 + (g % 4)));
            if (g == 4) bus.req_valid = 4'b0000;
            tick();
        end

        // Backpressure: response held 5 cycles while requester 2 waits.
        set_x(1, 32'h4049_0FDB);
        bus.req_valid  = 4'b0010;
        bus.resp_ready = 1'b0;
        #1;
        chk("t4_grant1", bus.req_ready, 4'b0010);
        tick();
        set_x(2, 32'h3E00_0000);
        bus.req_valid = 4'b0100;
        wait_resp(n);
        chk("t4_latency", n, 8);
        for (int s = 0; s < 5; s++) begin
            chk("t4_stall_valid", bus.resp_valid, 1'b1);
            chk("t4_stall_id", bus.resp_id, 2'd1);
            chk("t4_stall_y", bus.resp_y, exp_model(32'h4049_0FDB));
            chk("t4_stall_ready", bus.req_ready, 4'b0000);
            tick();
        end
        bus.resp_ready = 1'b1;
        chk("t4_hold_valid", bus.resp_valid, 1'b1);
        tick();
        chk("t4_grant2", bus.req_ready, 4'b0100);
        chk("t4_post_valid", bus.resp_valid, 1'b0);
        tick();
        bus.req_valid = 4'b0000;
        wait_resp(n);
        chk("t4_latency2", n, 8);
        chk("t4_id2", bus.resp_id, 2'd2);
        chk("t4_y2", bus.resp_y, exp_model(32'h3E00_0000));
        tick();

        // Timeout with a dead unit, then a normal operation.
        stub_ok = 1'b0;
        do_op(0, 32'h4120_0000, 16, 1'b1, 32'h0, "t5");
        chk("t5_valid", bus.resp_valid, 1'b1);
        chk("t5_enb", bus.exp_enb, 1'b0);
        stub_ok = 1'b1;
        tick();
        do_op(1, 32'h3DCC_CCCD, 8, 1'b0, exp_model(32'h3DCC_CCCD), "t5b");
        tick();

        // Reset during RUN cycle 3 discards the operation and restores priority.
        set_x(2, 32'h3F00_0000);
        bus.req_valid = 4'b0100;
        #1;
        chk("t6_grant", bus.req_ready, 4'b0100);
        tick();
        set_x(0, 32'h4000_0000);
        bus.req_valid = 4'b0101;
        tick();
        tick();
        tick();
        chk("t6_run_enb", bus.exp_enb, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_enb", bus.exp_enb, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_valid", bus.resp_valid, 1'b0);
        chk("t6_exp_x", bus.exp_x, 32'h0);
        #1;
        chk("t6_first_grant", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = 4'b0000;
        wait_resp(n);
        chk("t6_latency", n, 8);
        chk("t6_id", bus.resp_id, 2'd0);
        chk("t6_y", bus.resp_y, exp_model(32'h4000_0000));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
